// File: rtl/runner_pkg.sv
// Shared helpers for the runner datapath: width-ratio derivation and lane masking.
package runner_pkg;

    // Widest word the lane-mask helper can describe.
    localparam int MASK_W_MAX = 1024;

    function automatic int ratio_f(input int width_in, input int width_out);
        if (width_in < 1) begin
            return 1;
        end
        return width_out / width_in;
    endfunction

    function automatic int cnt_w_f(input int ratio);
        return $clog2(ratio + 1);
    endfunction

    // Ones in lanes 0..lanes-1, zeros in every lane at or above `lanes`.
    function automatic logic [MASK_W_MAX-1:0] lane_mask_f(input int lanes, input int width_in);
        logic [MASK_W_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W_MAX; i++) begin
            m[i] = (i < lanes * width_in);
        end
        return m;
    endfunction

endpackage

// File: rtl/runner_packer.sv
// Packs WIDTH_IN-bit beats little-endian into WIDTH_OUT-bit words; words closed
// early by in_last are zero-padded above the last written lane.
module runner_packer
    import runner_pkg::*;
#(
    parameter int WIDTH_IN  = 4,
    parameter int WIDTH_OUT = 8,
    localparam int RATIO    = ratio_f(WIDTH_IN, WIDTH_OUT),
    localparam int CNT_W    = cnt_w_f(RATIO)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_IN-1:0]  in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_OUT-1:0] out_data,
    output logic [CNT_W-1:0]     out_lanes,
    output logic                 out_last
);

    if ((WIDTH_IN < 1) || (WIDTH_OUT < WIDTH_IN) ||
        ((WIDTH_OUT % ((WIDTH_IN < 1) ? 1 : WIDTH_IN)) != 0)) begin : g_bad_width
        $fatal(1, "runner_packer: WIDTH_OUT must be a positive multiple of WIDTH_IN");
    end

    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    logic [WIDTH_OUT-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     lane_q, lane_d;
    logic [WIDTH_OUT-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]     out_lanes_q, out_lanes_d;
    logic                 out_last_q, out_last_d;
    logic                 out_valid_q, out_valid_d;

    logic                 accept;
    logic                 take;
    logic                 complete;
    logic [WIDTH_OUT-1:0] beat_shifted;
    logic [WIDTH_OUT-1:0] keep_mask;

    assign in_ready     = !out_valid_q || out_ready;
    assign accept       = in_valid && in_ready;
    assign take         = out_valid_q && out_ready;
    assign complete     = (lane_q == LAST_LANE) || in_last;
    assign beat_shifted = WIDTH_OUT'(in_data) << (int'(lane_q) * WIDTH_IN);
    assign keep_mask    = WIDTH_OUT'(lane_mask_f(int'(lane_q) + 1, WIDTH_IN));

    always_comb begin
        acc_d       = acc_q;
        lane_d      = lane_q;
        out_data_d  = out_data_q;
        out_lanes_d = out_lanes_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (take) begin
            out_valid_d = 1'b0;
        end

        // A completing beat may reload the output in the same cycle it is taken.
        if (accept) begin
            if (complete) begin
                out_data_d  = (acc_q | beat_shifted) & keep_mask;
                out_lanes_d = lane_q + CNT_W'(1);
                out_last_d  = in_last;
                out_valid_d = 1'b1;
                acc_d       = '0;
                lane_d      = '0;
            end else begin
                acc_d  = acc_q | beat_shifted;
                lane_d = lane_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            lane_q      <= '0;
            out_data_q  <= '0;
            out_lanes_q <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            lane_q      <= lane_d;
            out_data_q  <= out_data_d;
            out_lanes_q <= out_lanes_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_lanes = out_lanes_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_runner_packer.sv
// Directed bench for runner_packer in 4->8, 4->16 and 8->8 configurations.
module tb_runner_packer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // 4 -> 8
    logic       a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_last;
    logic [3:0] a_in_data;
    logic [7:0] a_out_data;
    logic [1:0] a_out_lanes;
    // 4 -> 16
    logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_last;
    logic [3:0]  b_in_data;
    logic [15:0] b_out_data;
    logic [2:0]  b_out_lanes;
    // 8 -> 8
    logic       c_in_valid, c_in_ready, c_in_last, c_out_valid, c_out_ready, c_out_last;
    logic [7:0] c_in_data;
    logic [7:0] c_out_data;
    logic [0:0] c_out_lanes;

    runner_packer #(.WIDTH_IN(4), .WIDTH_OUT(8)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_lanes(a_out_lanes), .out_last(a_out_last)
    );

    runner_packer #(.WIDTH_IN(4), .WIDTH_OUT(16)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_lanes(b_out_lanes), .out_last(b_out_last)
    );

    runner_packer #(.WIDTH_IN(8), .WIDTH_OUT(8)) u_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_last(c_in_last),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_lanes(c_out_lanes), .out_last(c_out_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [3:0] d, input logic last);
        a_in_valid = 1'b1; a_in_data = d; a_in_last = last;
        tick();
        a_in_valid = 1'b0; a_in_last = 1'b0;
    endtask

    task automatic send_b(input logic [3:0] d, input logic last);
        b_in_valid = 1'b1; b_in_data = d; b_in_last = last;
        tick();
        b_in_valid = 1'b0; b_in_last = 1'b0;
    endtask

    task automatic send_c(input logic [7:0] d, input logic last);
        c_in_valid = 1'b1; c_in_data = d; c_in_last = last;
        tick();
        c_in_valid = 1'b0; c_in_last = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = 0; a_in_data = 0; a_in_last = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_data = 0; b_in_last = 0; b_out_ready = 1;
        c_in_valid = 0; c_in_data = 0; c_in_last = 0; c_out_ready = 1;

        #2;
        check("rst_valid", a_out_valid, 0);
        check("rst_data",  a_out_data,  0);
        check("rst_lanes", a_out_lanes, 0);
        check("rst_last",  a_out_last,  0);
        check("rst_ready", a_in_ready,  1);
        #10 rst_n = 1'b1;
        tick();

        // Full words 4->8
        send_a(4'h3, 0);
        check("full_w0_pending", a_out_valid, 0);
        send_a(4'hA, 0);
        check("full_w0_valid", a_out_valid, 1);
        check("full_w0_data",  a_out_data,  8'hA3);
        check("full_w0_lanes", a_out_lanes, 2);
        check("full_w0_last",  a_out_last,  0);
        send_a(4'h5, 0);
        check("full_w1_pending", a_out_valid, 0);
        send_a(4'hC, 0);
        check("full_w1_valid", a_out_valid, 1);
        check("full_w1_data",  a_out_data,  8'hC5);
        check("full_w1_lanes", a_out_lanes, 2);
        tick();
        check("full_idle_valid", a_out_valid, 0);

        // Backpressure 4->8
        a_out_ready = 1'b0;
        send_a(4'h3, 0);
        send_a(4'hA, 0);
        check("bp_valid", a_out_valid, 1);
        check("bp_data",  a_out_data,  8'hA3);
        a_in_valid = 1'b1; a_in_data = 4'h5; a_in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", a_in_ready, 0);
            tick();
            check("bp_hold_data",  a_out_data,  8'hA3);
            check("bp_hold_valid", a_out_valid, 1);
        end
        a_out_ready = 1'b1;
        #1;
        check("bp_release_ready", a_in_ready, 1);
        tick();
        check("bp_after_take", a_out_valid, 0);
        a_in_data = 4'hC;
        tick();
        a_in_valid = 1'b0;
        check("bp_resume_valid", a_out_valid, 1);
        check("bp_resume_data",  a_out_data,  8'hC5);
        tick();
        check("bp_no_dup", a_out_valid, 0);

        // Back-to-back take/reload on lane 0 via in_last
        send_a(4'h7, 1);
        check("b2b_w0_data",  a_out_data,  8'h07);
        check("b2b_w0_lanes", a_out_lanes, 1);
        check("b2b_w0_last",  a_out_last,  1);
        send_a(4'h8, 1);
        check("b2b_w1_valid", a_out_valid, 1);
        check("b2b_w1_data",  a_out_data,  8'h08);
        tick();
        check("b2b_drain", a_out_valid, 0);

        // Early close 4->16
        send_b(4'h1, 0);
        send_b(4'h2, 1);
        check("early_valid", b_out_valid, 1);
        check("early_data",  b_out_data,  16'h0021);
        check("early_lanes", b_out_lanes, 2);
        check("early_last",  b_out_last,  1);
        send_b(4'h7, 0);
        check("early_next_pending", b_out_valid, 0);
        send_b(4'h8, 1);
        check("early_next_data",  b_out_data,  16'h0087);
        check("early_next_lanes", b_out_lanes, 2);
        tick();

        // Reset mid-word 4->16
        send_b(4'h1, 0);
        send_b(4'h2, 0);
        rst_n = 1'b0;
        #2;
        check("rstmid_valid", b_out_valid, 0);
        check("rstmid_data",  b_out_data,  0);
        check("rstmid_lanes", b_out_lanes, 0);
        check("rstmid_last",  b_out_last,  0);
        check("rstmid_ready", b_in_ready,  1);
        rst_n = 1'b1;
        tick();
        send_b(4'h4, 0);
        send_b(4'h5, 0);
        send_b(4'h6, 0);
        check("rstmid_pending", b_out_valid, 0);
        send_b(4'h7, 0);
        check("rstmid_valid2", b_out_valid, 1);
        check("rstmid_data2",  b_out_data,  16'h7654);
        check("rstmid_lanes2", b_out_lanes, 4);
        check("rstmid_last2",  b_out_last,  0);

        // RATIO == 1, 8->8
        send_c(8'h5A, 0);
        check("r1_valid", c_out_valid, 1);
        check("r1_data",  c_out_data,  8'h5A);
        check("r1_lanes", c_out_lanes, 1);
        check("r1_last",  c_out_last,  0);
        send_c(8'h3C, 0);
        check("r1_b2b_valid", c_out_valid, 1);
        check("r1_b2b_data",  c_out_data,  8'h3C);
        send_c(8'hFF, 1);
        check("r1_last_data", c_out_data, 8'hFF);
        check("r1_last_flag", c_out_last, 1);
        tick();
        check("r1_drain", c_out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
